uart_transmitter: RTL and testbench

Asynchronous UART transmitter that serialises bytes onto a single line as 8N1 frames, LSB first, at a fixed baud rate derived from the system clock. It is the transmit-side companion to the team's UART receivers: it sits between on-chip logic (debug and status reporting from the processor) and the board TX pin. A small FIFO absorbs bursts of writes so producers need not wait for each frame to complete.

---
 rtl/uart_transmitter.sv | 170 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO; LSB first, registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_transmitter #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_out,
  output logic       busy
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(BIT_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            uart_q, uart_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            push, pop, timer_end, fifo_nonempty;

  assign tx_ready      = (count_q != C_FULL);
  assign busy          = (state_q != S_IDLE) || (count_q != '0);
  assign uart_out      = uart_q;
  assign push          = tx_valid && tx_ready;
  assign timer_end     = (timer_q == T_LAST);
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        if (timer_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (timer_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_end) begin
          state_d = S_STOP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (timer_end) begin
          timer_d = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so the registered output tracks it.
    unique case (state_d)
      S_START:  uart_d = 1'b0;
      S_DATA:   uart_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: uart_d = ^shift_d;
`endif
      default:  uart_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      uart_q    <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      uart_q    <= uart_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 16 clocks per bit; honours UART_TX_PARITY_EN.
module tb_uart_transmitter;

  localparam int CLK_FREQ   = 16;
  localparam int BAUD_RATE  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int BC         = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_out;
  logic       busy;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_out(uart_out),
    .busy    (busy)
  );

  // frame[i] is the i-th line bit of the 8N1 frame (start first); par is even parity.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   idxq[$];

  function automatic logic [10:0] frame_of(input int i);
`ifdef UART_TX_PARITY_EN
    return {1'b1, vecs[i].par, vecs[i].frame[8:0]};
`else
    return {1'b0, vecs[i].frame};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    chk("ready_before_push", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Called just after the edge on which the start bit appeared; samples bit centres.
  task automatic check_bits(input logic [10:0] fr);
    for (int i = 0; i < NB; i++) begin
      repeat ((i == 0) ? BC / 2 : BC) @(posedge clk);
      #1;
      chk($sformatf("line_bit%0d", i), uart_out, fr[i]);
    end
  endtask

  task automatic run_frames();
    for (int k = 0; k < idxq.size(); k++) begin
      check_bits(frame_of(idxq[k]));
      repeat (BC / 2 - 1) @(posedge clk);
      #1;
      chk("stop_last_cycle", uart_out, 1);
      chk("busy_in_stop", busy, 1);
      @(posedge clk);
      #1;
      if (k < idxq.size() - 1) begin
        chk("next_start_no_gap", uart_out, 0);
      end else begin
        chk("idle_after_frame", uart_out, 1);
        chk("busy_after_frame", busy, 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h61, 10'b1011000010, 1'b1};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h55, 10'b1010101010, 1'b0};
    vecs[4] = '{8'hAA, 10'b1101010100, 1'b0};
    vecs[5] = '{8'h0F, 10'b1000011110, 1'b0};
    vecs[6] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[7] = '{8'h3C, 10'b1001111000, 1'b0};

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_line", uart_out, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      chk("idle_line", uart_out, 1);
      chk("idle_ready", tx_ready, 1);
      chk("idle_busy", busy, 0);
    end

    // Single frames from the vector table.
    for (int v = 0; v < 8; v++) begin
      push(vecs[v].data);
      chk("line_high_at_accept", uart_out, 1);
      chk("busy_at_accept", busy, 1);
      @(posedge clk);
      #1;
      chk("line_falls", uart_out, 0);
      idxq.delete();
      idxq.push_back(v);
      run_frames();
      repeat (3) @(posedge clk);
    end

    // Burst of five: FIFO fills, tx_ready returns only after the first stop-end pop.
    push(vecs[1].data);
    @(posedge clk);
    #1;
    chk("burst_line_falls", uart_out, 0);
    idxq.delete();
    for (int k = 1; k <= 5; k++) idxq.push_back(k);
    fork
      begin
        for (int k = 2; k <= 5; k++) push(vecs[k].data);
        chk("ready_low_when_full", tx_ready, 0);
        repeat (10 * BC - 5 + (NB - 10) * BC) @(posedge clk);
        #1;
        chk("ready_low_before_pop", tx_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_pop", tx_ready, 1);
      end
      run_frames();
    join
    repeat (3) @(posedge clk);

    // Push coinciding with a stop-end pop at depth-1: occupancy must hold at 3.
    push(vecs[0].data);
    @(posedge clk);
    #1;
    chk("coll_line_falls", uart_out, 0);
    idxq.delete();
    idxq.push_back(0);
    idxq.push_back(6);
    idxq.push_back(7);
    idxq.push_back(3);
    idxq.push_back(4);
    idxq.push_back(2);
    fork
      begin
        push(vecs[6].data);
        push(vecs[7].data);
        push(vecs[3].data);
        chk("ready_at_three", tx_ready, 1);
        repeat (NB * BC - 4) @(posedge clk);
        push(vecs[4].data);
        chk("ready_after_push_pop", tx_ready, 1);
        push(vecs[2].data);
        chk("ready_full_after_extra", tx_ready, 0);
      end
      run_frames();
    join
    repeat (3) @(posedge clk);

    // Reset mid-DATA with two bytes queued.
    push(vecs[7].data);
    push(8'h11);
    push(8'h22);
    repeat (4 * BC + 7) @(posedge clk);
    #1;
    chk("pre_reset_bit", uart_out, vecs[7].frame[4]);
    chk("pre_reset_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_line", uart_out, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * NB * BC) begin
      @(posedge clk);
      #1;
      chk("post_rst_line", uart_out, 1);
      chk("post_rst_busy", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
